instruct_mem_loader: RTL and testbench

- Avalon-MM initiator that boots the 4134 x 32 dual-port instruction memory through its second slave port (s2).
- Accepts a byte stream from the host bridge, assembles little-endian 32-bit words and writes them sequentially from word address 0.
- After writing, reads the image back, checks it against a running 32-bit sum, and holds the CPU in reset until the load passes.

---
 rtl/instruct_mem_loader.sv | 198 +++++++++++++++++++
 tb/tb_instruct_mem_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruct_mem_loader.sv
// instruct_mem_loader
//   Boots the dual-port instruction memory through its s2 Avalon-MM slave
//   port. A host byte stream (16-bit little-endian word count N, then 4*N
//   little-endian data bytes) is assembled into 32-bit words. The words are
//   written to addresses 0..N-1, then read back in a pipelined burst.
//   Their 32-bit sum is compared with the sum of what was written, and the
//   CPU is released from reset only when the two sums match.
//
// Ports
//   clk, reset_n          : single clock, synchronous active-low reset
//   start                 : one-cycle pulse, begins a load when idle
//   in_data/in_valid/
//   in_ready              : byte stream handshake (transfer = valid & ready)
//   address, byteenable,
//   chipselect, write,
//   writedata, readdata   : Avalon-MM initiator toward memory port s2
//                           (readdata is valid one cycle after the address)
//   busy                  : load in progress
//   done / error          : sticky pass / fail flags, cleared by start
//   cpu_reset_req         : held high until a load passes
module instruct_mem_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 4134
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [3:0]            byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [31:0]           writedata,
  input  logic [31:0]           readdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_reset_req
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_CHECK,
    S_BYTES,
    S_WRITE,
    S_RD,
    S_RDLAST,
    S_CMP,
    S_PASS,
    S_FAIL
  } state_t;

  state_t                state_reg, state_next;
  logic [15:0]           count_reg;
  logic [ADDR_WIDTH-1:0] index_reg;
  logic [1:0]            byte_cnt_reg;
  logic [31:0]           word_reg;
  logic [31:0]           wr_sum_reg;
  logic [31:0]           rd_sum_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  error_reg;
  logic                  cpu_reset_req_reg;

  // Compare in 32 bits, so the 16-bit count and the word index line up
  // whatever ADDR_WIDTH is.
  logic [31:0] index_ext;
  logic [31:0] count_ext;
  logic        last_word;
  logic        count_bad;

  assign index_ext = 32'(index_reg);
  assign count_ext = 32'(count_reg);
  assign last_word = (index_ext == count_ext - 32'd1);
  assign count_bad = (count_reg == 16'd0) || (count_ext > 32'(DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:   if (start) state_next = S_HDR0;
      S_HDR0:   if (in_valid) state_next = S_HDR1;
      S_HDR1:   if (in_valid) state_next = S_CHECK;
      S_CHECK:  state_next = count_bad ? S_FAIL : S_BYTES;
      S_BYTES:  if (in_valid && byte_cnt_reg == 2'd3) state_next = S_WRITE;
      S_WRITE:  state_next = last_word ? S_RD : S_BYTES;
      S_RD:     if (last_word) state_next = S_RDLAST;
      S_RDLAST: state_next = S_CMP;
      S_CMP:    state_next = (rd_sum_reg == wr_sum_reg) ? S_PASS : S_FAIL;
      S_PASS:   state_next = S_IDLE;
      S_FAIL:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    unique case (state_reg)
      S_HDR0, S_HDR1, S_BYTES: in_ready = 1'b1;
      S_WRITE: begin
        chipselect = 1'b1;
        write      = 1'b1;
      end
      S_RD:    chipselect = 1'b1;
      default: ;
    endcase
    byteenable    = chipselect ? 4'hF : 4'h0;
    address       = chipselect ? index_reg : '0;
    writedata     = word_reg;
    busy          = busy_reg;
    done          = done_reg;
    error         = error_reg;
    cpu_reset_req = cpu_reset_req_reg;
  end

  // Datapath: count capture, word assembly, index, checksums, status flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg         <= '0;
      index_reg         <= '0;
      byte_cnt_reg      <= '0;
      word_reg          <= '0;
      wr_sum_reg        <= '0;
      rd_sum_reg        <= '0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      error_reg         <= 1'b0;
      cpu_reset_req_reg <= 1'b1;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (start) begin
            busy_reg          <= 1'b1;
            done_reg          <= 1'b0;
            error_reg         <= 1'b0;
            cpu_reset_req_reg <= 1'b1;
            wr_sum_reg        <= '0;
            index_reg         <= '0;
            byte_cnt_reg      <= '0;
          end
        end
        S_HDR0: if (in_valid) count_reg[7:0]  <= in_data;
        S_HDR1: if (in_valid) count_reg[15:8] <= in_data;
        S_BYTES: begin
          if (in_valid) begin
            // Shift right so the first byte ends up in bits [7:0].
            word_reg     <= {in_data, word_reg[31:8]};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
          end
        end
        S_WRITE: begin
          wr_sum_reg <= wr_sum_reg + word_reg;
          if (last_word) begin
            index_reg  <= '0;
            rd_sum_reg <= '0;
          end else begin
            index_reg <= index_reg + 1'b1;
          end
        end
        S_RD: begin
          // readdata belongs to the address of the previous cycle; the first
          // RD cycle has nothing in flight yet.
          if (index_reg != '0) rd_sum_reg <= rd_sum_reg + readdata;
          // Hold at N-1 on the last read so the address never passes it.
          if (!last_word) index_reg <= index_reg + 1'b1;
        end
        S_RDLAST: rd_sum_reg <= rd_sum_reg + readdata;
        S_PASS: begin
          busy_reg          <= 1'b0;
          done_reg          <= 1'b1;
          cpu_reset_req_reg <= 1'b0;
        end
        S_FAIL: begin
          busy_reg  <= 1'b0;
          error_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruct_mem_loader.sv
module tb_instruct_mem_loader;
  localparam int AW    = 13;
  localparam int DEPTH = 4134;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_reset_req;

  instruct_mem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(readdata),
    .busy(busy), .done(done), .error(error), .cpu_reset_req(cpu_reset_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: synchronous write, read data one cycle after the address.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rd_data_q = 32'h0;
  bit          corrupt = 1'b0;

  always @(posedge clk) begin
    if (chipselect && write) mem[address] <= writedata;
    if (chipselect && !write)
      rd_data_q <= mem[address] ^ ((corrupt && address == AW'(1)) ? 32'd1 : 32'd0);
  end
  assign readdata = rd_data_q;

  // Reference model: expected write words in order, expected read count.
  logic [31:0] exp_wr_q[$];
  int          wr_idx = 0;
  int          rd_idx = 0;
  int          exp_n_reads = 0;
  int          last_wr_addr = -1;
  logic [31:0] wr_log [0:1];
  logic [7:0]  stream[$];

  // Per-cycle compare against the model
  always @(negedge clk) begin
    check("byteenable", {28'h0, byteenable}, chipselect ? 32'hF : 32'h0);
    check("flags_exclusive", {31'h0, done & error}, 32'h0);
    if (chipselect && write) begin
      check("in_ready_in_write", {31'h0, in_ready}, 32'h0);
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, none required", address, writedata);
      end else begin
        check("write_addr", 32'(address), wr_idx);
        check("write_data", writedata, exp_wr_q.pop_front());
        if (wr_idx < 2) wr_log[wr_idx] = writedata;
        last_wr_addr = int'(address);
        wr_idx++;
      end
    end else if (chipselect) begin
      check("in_ready_in_read", {31'h0, in_ready}, 32'h0);
      if (exp_wr_q.size() != 0 || rd_idx >= exp_n_reads) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: addr %0d, reads done %0d of %0d", address, rd_idx, exp_n_reads);
      end else begin
        check("read_addr", 32'(address), rd_idx);
        rd_idx++;
      end
    end else if (rd_idx > 0 && rd_idx < exp_n_reads) begin
      checks++;
      errors++;
      $display("FAIL read_gap: no read at index %0d of %0d", rd_idx, exp_n_reads);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
    check({tag, "_chipselect"}, {31'h0, chipselect}, 32'h0);
    check({tag, "_write"}, {31'h0, write}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_error"}, {31'h0, error}, 32'h0);
    check({tag, "_address"}, 32'(address), 32'h0);
    check({tag, "_writedata"}, writedata, 32'h0);
    check({tag, "_byteenable"}, {28'h0, byteenable}, 32'h0);
    check({tag, "_cpu_reset_req"}, {31'h0, cpu_reset_req}, 32'h1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte (after optional random idle cycles) and hold it until taken.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit acc;
    int guard;
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    acc      = 1'b0;
    guard    = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL byte_accept_timeout: in_ready 0 for %0d cycles, required 1", guard);
        $fatal(1, "byte never accepted");
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic make_random(input int n);
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom_range(255)));
  endtask

  task automatic set_model(input int n);
    bit ok;
    ok = (n != 0 && n <= DEPTH);
    exp_wr_q.delete();
    wr_idx       = 0;
    rd_idx       = 0;
    last_wr_addr = -1;
    exp_n_reads  = ok ? n : 0;
    if (ok)
      for (int i = 0; i < n; i++)
        exp_wr_q.push_back({stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]});
  endtask

  // Run the whole stream in 'stream' as one load and check its outcome.
  task automatic run_stream(input string tag, input int gap_pct, input bit corr, input bit poke);
    int n;
    bit ok;
    bit pass;
    int g;
    n    = int'({stream[1], stream[0]});
    ok   = (n != 0 && n <= DEPTH);
    pass = ok && !corr;
    corrupt = corr;
    set_model(n);
    pulse_start();
    check({tag, "_busy_after_start"}, {31'h0, busy}, 32'h1);
    check({tag, "_done_after_start"}, {31'h0, done}, 32'h0);
    check({tag, "_error_after_start"}, {31'h0, error}, 32'h0);
    check({tag, "_cpu_reset_after_start"}, {31'h0, cpu_reset_req}, 32'h1);
    for (int k = 0; k < stream.size(); k++) begin
      send_byte(stream[k], gap_pct);
      if (k == 1 && !ok) begin
        // CHECK cycle, then FAIL cycle, then error shows.
        check({tag, "_error_cycle1"}, {31'h0, error}, 32'h0);
        @(posedge clk); #1;
        check({tag, "_error_cycle2"}, {31'h0, error}, 32'h0);
        @(posedge clk); #1;
        check({tag, "_error_cycle3"}, {31'h0, error}, 32'h1);
      end
      if (k == 1 && poke) pulse_start();
    end
    g = 0;
    while (busy && g < 2 * n + 100) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    check({tag, "_finished_in_time"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, {31'h0, pass});
    check({tag, "_error"}, {31'h0, error}, {31'h0, !pass});
    check({tag, "_cpu_reset_req"}, {31'h0, cpu_reset_req}, {31'h0, !pass});
    check({tag, "_writes_left"}, exp_wr_q.size(), 32'h0);
    check({tag, "_reads_made"}, rd_idx, exp_n_reads);
    $display("load %s N=%0d gap=%0d corrupt=%0d done=%0d error=%0d cpu_reset_req=%0d",
             tag, n, gap_pct, corr, done, error, cpu_reset_req);
    corrupt = 1'b0;
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic load
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_stream("basic", 0, 1'b0, 1'b0);
    check("basic_word0", wr_log[0], 32'h12345678);
    check("basic_word1", wr_log[1], 32'hDEADBEEF);
    check("basic_mem1", mem[1], 32'hDEADBEEF);

    // Zero count
    stream = '{8'h00, 8'h00};
    run_stream("zero", 0, 1'b0, 1'b0);

    // Oversize count 4135
    stream = '{8'h27, 8'h10};
    run_stream("oversize", 0, 1'b0, 1'b0);

    // Random stalls, plus a start pulse mid-load that must be ignored
    make_random(8);
    run_stream("stall", 40, 1'b0, 1'b1);

    // Readback corruption of word 1
    make_random(3);
    run_stream("corrupt", 0, 1'b1, 1'b0);

    // Random loads
    for (int t = 0; t < 4; t++) begin
      make_random($urandom_range(12, 1));
      run_stream("random", $urandom_range(50), 1'($urandom_range(1)), 1'b0);
    end

    // Reset mid-load after the first of three words is written
    make_random(3);
    set_model(3);
    pulse_start();
    for (int k = 0; k < 6; k++) send_byte(stream[k], 0);
    @(posedge clk); #1;
    check("midreset_word0_written", wr_idx, 32'd1);
    reset_n = 1'b0;
    exp_wr_q.delete();
    exp_n_reads = 0;
    rd_idx = 0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    make_random(3);
    run_stream("after_reset", 10, 1'b0, 1'b0);

    // Maximum count
    make_random(DEPTH);
    run_stream("max", 0, 1'b0, 1'b0);
    check("max_last_addr", last_wr_addr, 32'd4133);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
